// File: rtl/i2s_frame_lock_pkg.sv
// rtl/i2s_frame_lock_pkg.sv - shared constants and lock state encoding for the I2S frame qualifier
// Purpose: default frame geometry, error counter width and FSM state type.
package i2s_frame_lock_pkg;

  localparam int BITS_PER_HALF_DEF = 32;  // BCK cycles per LRCK half (64 BCK/frame)
  localparam int LOCK_HALVES_DEF   = 16;  // consecutive good halves to declare lock
  localparam int TIMEOUT_DEF       = 64;  // BCK cycles without LRCK edge => loss
  localparam int ERR_CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/i2s_frame_lock_if.sv
// rtl/i2s_frame_lock_if.sv - I2S stream in/out bundle for the frame qualifier
// Purpose: groups the qualifier's stream and status signals.
// Ports (signals):
//   lrck, datain        source -> qualifier
//   lrckout, dataout    delayed, gated stream towards the splitter
//   lock, mute          qualification status
//   frame_err, err_cnt  lock-loss pulse and saturating loss count
//   led1                active-low lock indicator
interface i2s_frame_lock_if;
  import i2s_frame_lock_pkg::*;

  logic                 lrck;
  logic                 datain;
  logic                 lrckout;
  logic                 dataout;
  logic                 lock;
  logic                 mute;
  logic                 frame_err;
  logic                 led1;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output lrck, datain,
    input  lrckout, dataout, lock, mute, frame_err, led1, err_cnt
  );

  modport slave (
    input  lrck, datain,
    output lrckout, dataout, lock, mute, frame_err, led1, err_cnt
  );

endinterface

// File: rtl/i2s_frame_lock_period_meter.sv
// rtl/i2s_frame_lock_period_meter.sv - LRCK half-period measurement in BCK cycles
// Purpose: detects LRCK edges, counts BCK cycles since the last edge and
// classifies each half as good/bad in its edge cycle, plus a stall timeout.
// Ports:
//   clk_i      BCK
//   rst_i      synchronous active-high reset
//   lrck_i     raw LRCK
//   edge_o     LRCK differs from its registered copy this cycle
//   fall_o     edge towards LRCK=0 (start of left word)
//   good_o     edge closing a half of exactly BITS_PER_HALF cycles
//   bad_o      edge closing any other half length
//   timeout_o  no edge and the counter is one step from TIMEOUT
module i2s_frame_lock_period_meter
  import i2s_frame_lock_pkg::*;
#(
  parameter int BITS_PER_HALF = BITS_PER_HALF_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lrck_i,
  output logic edge_o,
  output logic fall_o,
  output logic good_o,
  output logic bad_o,
  output logic timeout_o
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_GOOD = CW'(BITS_PER_HALF);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_WARN = CW'(TIMEOUT - 1);

  logic          lrck_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lr_edge;

  always_comb begin
    lr_edge = (lrck_i != lrck_q);
    cnt_d   = cnt_q;
    if (lr_edge) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrck_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lrck_q <= lrck_i;
      cnt_q  <= cnt_d;
    end
  end

  assign edge_o    = lr_edge;
  assign fall_o    = lr_edge & ~lrck_i;
  assign good_o    = lr_edge & (cnt_q == CNT_GOOD);
  // A saturated counter (stalled LRCK) never equals CNT_GOOD, so it lands here.
  assign bad_o     = lr_edge & (cnt_q != CNT_GOOD);
  // Counter saturates at TIMEOUT, so this can only fire once per stall.
  assign timeout_o = ~lr_edge & (cnt_q == CNT_WARN);

endmodule

// File: rtl/i2s_frame_lock.sv
// rtl/i2s_frame_lock.sv - I2S stream qualifier with lock detection and data mute
// Purpose: declares lock after LOCK_HALVES consecutive well-formed LRCK halves,
// passes LRCK/DATA through with one BCK of delay and zeroes data while unlocked.
// Ports:
//   bck_i  bit clock, all logic on its rising edge
//   rst_i  synchronous active-high reset
//   bus    stream/status bundle (slave side): lrck, datain in;
//          lrckout, dataout, lock, mute, frame_err, err_cnt, led1 out
module i2s_frame_lock
  import i2s_frame_lock_pkg::*;
#(
  parameter int BITS_PER_HALF = BITS_PER_HALF_DEF,
  parameter int LOCK_HALVES   = LOCK_HALVES_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                 bck_i,
  input  logic                 rst_i,
  i2s_frame_lock_if.slave      bus
);

  localparam int            GW          = $clog2(LOCK_HALVES + 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_HALVES);

  lock_state_e          state_q, state_d;
  logic [GW-1:0]        good_cnt_q, good_cnt_d;
  logic                 mute_q, mute_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 frame_err_q;
  logic                 lrckout_q;
  logic                 dataout_q;
  logic                 loss;

  logic lr_edge, lr_fall, half_good, half_bad, stall;

  i2s_frame_lock_period_meter #(
    .BITS_PER_HALF (BITS_PER_HALF),
    .TIMEOUT       (TIMEOUT)
  ) u_meter (
    .clk_i     (bck_i),
    .rst_i     (rst_i),
    .lrck_i    (bus.lrck),
    .edge_o    (lr_edge),
    .fall_o    (lr_fall),
    .good_o    (half_good),
    .bad_o     (half_bad),
    .timeout_o (stall)
  );

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    mute_d     = mute_q;
    loss       = 1'b0;
    case (state_q)
      ST_UNLOCK: begin
        mute_d = 1'b1;
        // The first edge only starts the measurement; its half is unknown.
        if (lr_edge) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
      end
      ST_ACQ: begin
        mute_d = 1'b1;
        if (stall) begin
          state_d = ST_UNLOCK;
        end else if (half_good) begin
          good_cnt_d = good_cnt_q + GW'(1);
          if (good_cnt_d == GOOD_TARGET) begin
            state_d = ST_LOCKED;
          end
        end else if (half_bad) begin
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (half_bad || stall) begin
          state_d = ST_UNLOCK;
          loss    = 1'b1;
          mute_d  = 1'b1;
        end else if (lr_fall) begin
          // Unmute only at a left-word boundary.
          mute_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_UNLOCK;
        mute_d  = 1'b1;
      end
    endcase

    err_cnt_d = err_cnt_q;
    if (loss && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge bck_i) begin
    if (rst_i) begin
      state_q     <= ST_UNLOCK;
      good_cnt_q  <= '0;
      mute_q      <= 1'b1;
      err_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      lrckout_q   <= 1'b0;
      dataout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      mute_q      <= mute_d;
      err_cnt_q   <= err_cnt_d;
      frame_err_q <= loss;
      lrckout_q   <= bus.lrck;
      // Gate with the mute value registered alongside, so output and MUTE agree.
      dataout_q   <= mute_d ? 1'b0 : bus.datain;
    end
  end

  assign bus.lrckout   = lrckout_q;
  assign bus.dataout   = dataout_q;
  assign bus.lock      = (state_q == ST_LOCKED);
  assign bus.led1      = (state_q != ST_LOCKED);
  assign bus.mute      = mute_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_i2s_frame_lock.sv
// tb/tb_i2s_frame_lock.sv - scoreboard bench for the I2S frame qualifier
module tb_i2s_frame_lock;

  typedef struct packed {
    logic       lrckout;
    logic       dataout;
    logic       lock;
    logic       mute;
    logic       frame_err;
    logic       led1;
    logic [7:0] err_cnt;
  } obs_t;

  localparam logic [31:0] PAT_L = 32'hA5A5A500;
  localparam logic [31:0] PAT_R = 32'h5A5A5A00;

  logic bck = 1'b0;
  always #5 bck = ~bck;

  logic r_v [2];
  logic l_v [2];
  logic d_v [2];
  int   pos [2];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: time stamps of LRCK edges, not counters.
  int m_bph [2] = '{32, 4};
  int m_lh  [2] = '{16, 2};
  int m_to  [2] = '{64, 8};
  bit m_lq     [2];
  int m_t      [2];
  int m_last   [2];
  int m_run    [2];
  int m_err    [2];
  bit m_acq    [2];
  bit m_locked [2];
  bit m_muted  [2];

  obs_t q0[$];
  obs_t q1[$];

  i2s_frame_lock_if bus0 ();
  i2s_frame_lock_if bus1 ();

  assign bus0.lrck   = l_v[0];
  assign bus0.datain = d_v[0];
  assign bus1.lrck   = l_v[1];
  assign bus1.datain = d_v[1];

  i2s_frame_lock dut0 (
    .bck_i (bck),
    .rst_i (r_v[0]),
    .bus   (bus0)
  );

  i2s_frame_lock #(
    .BITS_PER_HALF (4),
    .LOCK_HALVES   (2),
    .TIMEOUT       (8)
  ) dut1 (
    .bck_i (bck),
    .rst_i (r_v[1]),
    .bus   (bus1)
  );

  task automatic chk(input int k, input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  task automatic chk1(input int k, input string nm, input logic act, input logic exp);
    chk(k, nm, {7'd0, act}, {7'd0, exp});
  endtask

  task automatic model_step(input int k);
    obs_t e;
    int   len;
    bit   ed, fl, gd, bd, to, loss;
    e = '0;
    if (r_v[k]) begin
      m_lq[k] = 1'b0; m_t[k] = 0; m_last[k] = 0; m_run[k] = 0; m_err[k] = 0;
      m_acq[k] = 1'b0; m_locked[k] = 1'b0; m_muted[k] = 1'b1;
      e.mute = 1'b1;
      e.led1 = 1'b1;
    end else begin
      len  = m_t[k] - m_last[k];
      ed   = (l_v[k] != m_lq[k]);
      fl   = ed && !l_v[k];
      gd   = ed && (len == m_bph[k]);
      bd   = ed && !gd;
      to   = !ed && (len == m_to[k] - 1);
      loss = 1'b0;
      if (m_locked[k]) begin
        if (bd || to) begin
          loss = 1'b1;
          m_locked[k] = 1'b0;
          m_muted[k]  = 1'b1;
          if (m_err[k] < 255) m_err[k]++;
        end else if (fl) begin
          m_muted[k] = 1'b0;
        end
      end else if (m_acq[k]) begin
        if (to) m_acq[k] = 1'b0;
        else if (gd) begin
          m_run[k]++;
          if (m_run[k] == m_lh[k]) begin
            m_locked[k] = 1'b1;
            m_acq[k]    = 1'b0;
          end
        end else if (bd) m_run[k] = 0;
      end else if (ed) begin
        m_acq[k] = 1'b1;
        m_run[k] = 0;
      end
      if (ed) m_last[k] = m_t[k];
      m_t[k]++;
      m_lq[k] = l_v[k];
      e.lrckout   = l_v[k];
      e.dataout   = m_muted[k] ? 1'b0 : d_v[k];
      e.lock      = m_locked[k];
      e.mute      = m_muted[k];
      e.frame_err = loss;
      e.led1      = !m_locked[k];
      e.err_cnt   = 8'(m_err[k]);
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge bck);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic play(input int k, input int len, input bit tog, input bit pat);
    logic [31:0] w;
    if (tog) begin
      l_v[k] = ~l_v[k];
      pos[k] = 0;
    end
    repeat (len) begin
      w = l_v[k] ? PAT_R : PAT_L;
      if (pat && pos[k] < 32) d_v[k] = w[31 - pos[k]];
      else                    d_v[k] = 1'($urandom);
      pos[k]++;
      tick();
    end
  endtask

  task automatic rst_pulse(input int k, input int n);
    r_v[k] = 1'b1;
    repeat (n) tick();
    r_v[k] = 1'b0;
  endtask

  task automatic compare(input int k, input obs_t a, input obs_t e);
    chk1(k, "lrckout",   a.lrckout,   e.lrckout);
    chk1(k, "dataout",   a.dataout,   e.dataout);
    chk1(k, "lock",      a.lock,      e.lock);
    chk1(k, "mute",      a.mute,      e.mute);
    chk1(k, "frame_err", a.frame_err, e.frame_err);
    chk1(k, "led1",      a.led1,      e.led1);
    chk(k,  "err_cnt",   a.err_cnt,   e.err_cnt);
  endtask

  always @(negedge bck) begin : monitor
    obs_t a, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {bus0.lrckout, bus0.dataout, bus0.lock, bus0.mute, bus0.frame_err, bus0.led1, bus0.err_cnt};
      compare(0, a, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {bus1.lrckout, bus1.dataout, bus1.lock, bus1.mute, bus1.frame_err, bus1.led1, bus1.err_cnt};
      compare(1, a, e);
    end
  end

  initial begin : stim
    int r;
    for (int k = 0; k < 2; k++) begin
      r_v[k] = 1'b1; l_v[k] = 1'b0; d_v[k] = 1'b0; pos[k] = 0;
    end
    l_v[0] = 1'b1;
    repeat (3) tick();
    r_v[0] = 1'b0;
    r_v[1] = 1'b0;

    // Clean frames from reset; first edge is the very first cycle.
    play(0, 32, 0, 0);
    for (int h = 1; h <= 15; h++) play(0, 32, 1, 0);
    chk1(0, "lock_before_16th", bus0.lock, 1'b0);
    play(0, 1, 1, 0);
    chk1(0, "lock_at_16th", bus0.lock, 1'b1);
    chk1(0, "mute_at_16th", bus0.mute, 1'b1);
    chk1(0, "led1_at_16th", bus0.led1, 1'b0);
    play(0, 31, 0, 0);
    play(0, 1, 1, 1);
    chk1(0, "unmute_at_fall", bus0.mute, 1'b0);
    play(0, 31, 0, 1);
    for (int h = 0; h < 20; h++) play(0, 32, 1, 1);

    // Short half while locked.
    play(0, 31, 1, 0);
    play(0, 1, 1, 0);
    chk1(0, "short_frame_err", bus0.frame_err, 1'b1);
    chk1(0, "short_mute", bus0.mute, 1'b1);
    chk1(0, "short_lock", bus0.lock, 1'b0);
    chk(0, "short_err_cnt", bus0.err_cnt, 8'd1);
    play(0, 1, 0, 0);
    chk1(0, "short_pulse_end", bus0.frame_err, 1'b0);
    play(0, 30, 0, 0);
    for (int h = 0; h < 40; h++) play(0, 32, 1, 1);

    // Static LRCK while locked.
    play(0, 150, 0, 0);
    chk(0, "stall_err_cnt", bus0.err_cnt, 8'd2);

    // Acquisition restarted by a 33-cycle half.
    for (int h = 0; h < 10; h++) play(0, 32, 1, 0);
    play(0, 33, 1, 0);
    for (int h = 0; h < 16; h++) play(0, 32, 1, 0);
    chk1(0, "acq_15_after_bad", bus0.lock, 1'b0);
    play(0, 1, 1, 0);
    chk1(0, "acq_16_after_bad", bus0.lock, 1'b1);
    play(0, 31, 0, 0);
    play(0, 32, 1, 1);
    play(0, 32, 1, 1);
    chk1(0, "pre_reset_mute", bus0.mute, 1'b0);

    // Reset while locked and unmuted.
    rst_pulse(0, 1);
    chk1(0, "rst_lock", bus0.lock, 1'b0);
    chk1(0, "rst_mute", bus0.mute, 1'b1);
    chk1(0, "rst_led1", bus0.led1, 1'b1);
    chk(0, "rst_err_cnt", bus0.err_cnt, 8'd0);
    for (int h = 0; h < 16; h++) play(0, 32, 1, 1);
    chk1(0, "relock_needs_full_acq", bus0.lock, 1'b0);
    for (int h = 0; h < 24; h++) play(0, 32, 1, 1);

    // Many lock losses on the small-geometry instance.
    for (int it = 0; it < 290; it++) begin
      play(1, 4, 1, 0);
      play(1, 4, 1, 0);
      play(1, 4, 1, 0);
      r = $urandom_range(0, 2);
      if (r == 0)      play(1, 3, 1, 0);
      else if (r == 1) play(1, $urandom_range(5, 6), 1, 0);
      else             play(1, 12, 1, 0);
    end

    // Randomized mix of good, off-by-one, wild and stalled halves.
    for (int it = 0; it < 350; it++) begin
      r = $urandom_range(0, 99);
      if (r < 85)      play(0, 32, 1, 1);
      else if (r < 89) play(0, 31, 1, 0);
      else if (r < 93) play(0, 33, 1, 0);
      else if (r < 96) play(0, $urandom_range(1, 80), 1, 0);
      else if (r < 99) play(0, $urandom_range(20, 90), 0, 0);
      else             rst_pulse(0, 1);
    end

    tick();
    repeat (2) @(negedge bck);
    #1;
    chk(1, "err_cnt_saturated", bus1.err_cnt, 8'd255);
    chk(0, "sb_drain0", 8'(q0.size()), 8'd0);
    chk(1, "sb_drain1", 8'(q1.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
